// File: rtl/vmul_pkg.sv
// Shared types and widths for the shared-multiplier arbiter.
//   state_t : arbiter FSM states
//   OPW     : operand width
//   PW      : product width
//   ACCW    : accumulator width (used only with VMUL_ARB_ACC_EN)
package vmul_pkg;
  localparam int OPW  = 4;
  localparam int PW   = 8;
  localparam int ACCW = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RESP = 2'd2
  } state_t;
endpackage

// File: rtl/vedic_mul_arbiter_if.sv
// Request/response bus between requester clients and the arbiter.
//   slave  : arbiter side (accepts requests, produces responses)
//   master : client/consumer side
// Optional macro VMUL_ARB_ACC_EN adds rsp_acc (running per-requester sum).
interface vedic_mul_arbiter_if #(parameter int NREQ = 4);
  import vmul_pkg::*;
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]     req_valid;
  logic [OPW*NREQ-1:0] req_a;
  logic [OPW*NREQ-1:0] req_b;
  logic [NREQ-1:0]     req_ready;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [PW-1:0]       rsp_p;
  logic [IDW-1:0]      rsp_id;
  logic                busy;
`ifdef VMUL_ARB_ACC_EN
  logic [ACCW-1:0]     rsp_acc;
`endif

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_p, rsp_id, busy
`ifdef VMUL_ARB_ACC_EN
    , output rsp_acc
`endif
  );

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_p, rsp_id, busy
`ifdef VMUL_ARB_ACC_EN
    , input rsp_acc
`endif
  );
endinterface

// File: rtl/tt_um_vedic_4x4.sv
// Combinational 4x4 unsigned Vedic (Urdhva-Tiryagbhyam) multiplier.
// Ports: i_a, i_b (4-bit operands) -> o_p (8-bit exact product).
module tt_um_vedic_4x4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  output logic [7:0] o_p
);
  // 2x2 vertical-and-crosswise cell
  function automatic logic [3:0] mul2(input logic [1:0] x, input logic [1:0] y);
    logic c;
    c = x[1] & y[0] & x[0] & y[1];
    return {x[1] & y[1] & c,
            (x[1] & y[1]) ^ c,
            (x[1] & y[0]) ^ (x[0] & y[1]),
            x[0] & y[0]};
  endfunction

  logic [3:0] w_q0, w_q1, w_q2, w_q3;
  logic [7:0] w_cross;

  assign w_q0    = mul2(i_a[1:0], i_b[1:0]);
  assign w_q1    = mul2(i_a[3:2], i_b[1:0]);
  assign w_q2    = mul2(i_a[1:0], i_b[3:2]);
  assign w_q3    = mul2(i_a[3:2], i_b[3:2]);
  assign w_cross = {4'b0, w_q1} + {4'b0, w_q2};
  assign o_p     = {4'b0, w_q0} + {w_cross[5:0], 2'b00} + {w_q3, 4'b0000};
endmodule

// File: rtl/vmul_rr_pick.sv
// Combinational round-robin picker.
// Ports: i_req (request vector), i_ptr (last served index)
//        -> o_gnt (one-hot), o_idx (granted index), o_any (any request).
// Search order starts just after i_ptr and wraps modulo NREQ.
module vmul_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [IDW-1:0]  o_idx,
  output logic            o_any
);
  int w_j;

  always_comb begin
    o_any = 1'b0;
    o_idx = '0;
    o_gnt = '0;
    w_j   = 0;
    // Walk farthest-to-nearest so the nearest hit after i_ptr overwrites the rest.
    for (int k = NREQ; k >= 1; k--) begin
      w_j = (int'(i_ptr) + k) % NREQ;
      if (i_req[w_j]) begin
        o_any = 1'b1;
        o_idx = IDW'(w_j);
      end
    end
    if (o_any) o_gnt[o_idx] = 1'b1;
  end
endmodule

// File: rtl/vedic_mul_arbiter.sv
// Shares one tt_um_vedic_4x4 among NREQ requesters: round-robin grant,
// operand capture, registered product, tagged valid/ready response.
// Ports: clk, rst_n (async active-low), bus (vedic_mul_arbiter_if.slave).
// Optional macro VMUL_ARB_ACC_EN: per-requester 12-bit wrapping accumulators,
// updated value returned on bus.rsp_acc alongside rsp_p.
//
// state | meaning
// IDLE  | waiting; grants a valid requester and captures its operands
// MUL   | product of captured operands registered into rsp_p/rsp_id
// RESP  | rsp_valid high; held until rsp_ready
module vedic_mul_arbiter
  import vmul_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  vedic_mul_arbiter_if.slave bus
);
  localparam int IDW = $clog2(NREQ);

  state_t          r_state, w_state_nxt;
  logic [IDW-1:0]  r_ptr, r_gnt_idx, r_rsp_id;
  logic [OPW-1:0]  r_op_a, r_op_b;
  logic [PW-1:0]   r_rsp_p, w_prod;
  logic [NREQ-1:0] w_gnt;
  logic [IDW-1:0]  w_idx;
  logic            w_any;

  vmul_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .i_req (bus.req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  tt_um_vedic_4x4 u_mul (
    .i_a (r_op_a),
    .i_b (r_op_b),
    .o_p (w_prod)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_any) w_state_nxt = MUL;
      MUL:     w_state_nxt = RESP;
      RESP:    if (bus.rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_ptr     <= IDW'(NREQ - 1);
      r_gnt_idx <= '0;
      r_op_a    <= '0;
      r_op_b    <= '0;
      r_rsp_p   <= '0;
      r_rsp_id  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && w_any) begin
        r_gnt_idx <= w_idx;
        r_op_a    <= bus.req_a[OPW*int'(w_idx) +: OPW];
        r_op_b    <= bus.req_b[OPW*int'(w_idx) +: OPW];
      end
      if (r_state == MUL) begin
        r_rsp_p  <= w_prod;
        r_rsp_id <= r_gnt_idx;
        r_ptr    <= r_gnt_idx;
      end
    end
  end

`ifdef VMUL_ARB_ACC_EN
  logic [ACCW-1:0] r_acc [NREQ];
  logic [ACCW-1:0] r_rsp_acc;
  logic [ACCW-1:0] w_acc_sum;

  assign w_acc_sum = r_acc[r_gnt_idx] + ACCW'(w_prod);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREQ; i++) r_acc[i] <= '0;
      r_rsp_acc <= '0;
    end else if (r_state == MUL) begin
      r_acc[r_gnt_idx] <= w_acc_sum;
      r_rsp_acc        <= w_acc_sum;
    end
  end

  assign bus.rsp_acc = r_rsp_acc;
`endif

  // Grant is combinational so a requester dropping valid is never granted.
  assign bus.req_ready = (r_state == IDLE) ? w_gnt : '0;
  assign bus.rsp_valid = (r_state == RESP);
  assign bus.rsp_p     = r_rsp_p;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.busy      = (r_state != IDLE);
endmodule
